op_fetch_queue: RTL
===================

# op_fetch_queue

Nibble instruction queue that sits directly upstream of the op decoder. A host writes program nibbles (opcodes and operands) with a valid/ready handshake. The queue presents the head nibble to the decoder and advances each time the decoder asserts `move_next`. With replay enabled, the queue keeps consumed nibbles so a loop body can be rewound and re-issued without reloading it.

## Interface
- `DEPTH`, 8, number of nibble entries; power of two, minimum 2
- `AW`, $clog2(DEPTH), pointer width (derived, not overridden)

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `wr_valid`  in  1  host offers `wr_data` this cycle
- `wr_data`  in  4  program nibble
- `wr_ready`  out  1  queue can accept a write (not full)
- `rd_next`  in  1  decoder consumes head; tied to op decoder `move_next`
- `rd_data`  out  4  head nibble; NOP (4'h0) when empty
- `rd_valid`  out  1  head nibble is real (queue not empty)
- `count`  out  AW+1  occupied entries counted from `base_ptr` to `wr_ptr`, range 0..DEPTH
- `ovf`  out  1  sticky: a write was attempted while full
- `rewind`  in  1  (REPLAY_EN only) `rd_ptr` <= `base_ptr`
- `release`  in  1  (REPLAY_EN only) frees consumed entries: `base_ptr` <= `rd_ptr`

## Operation
- State: storage array, `wr_ptr`, `rd_ptr`, `base_ptr`, each AW+1 bits with a wrap bit; `ovf`.
- Write accepted when `wr_valid && wr_ready`: store at `wr_ptr[AW-1:0]`, increment `wr_ptr`.
- `wr_ready` = (`count` != DEPTH), computed from current registered state only.
- `rd_valid` = (`rd_ptr` != `wr_ptr`).
- `rd_data` = storage[`rd_ptr`] when `rd_valid`, else 4'h0.
- `rd_next && rd_valid`: increment `rd_ptr`. `rd_next` on an empty queue is ignored.
- Without REPLAY_EN, `base_ptr` always equals `rd_ptr`, so a read frees its entry.
- Write while full: data dropped, pointers unchanged, `ovf` <= 1. Only reset clears `ovf`.
- All pointers wrap modulo 2*DEPTH. Full = `wr_ptr - base_ptr == DEPTH`.
- The queue does not parse opcodes. Operand nibbles (for example after PUSH 4'h1) pass through the queue like any other nibble.

## Timing
- Reset (async assert, sync deassert at the system level): all pointers 0, `ovf` 0, `rd_valid` 0, `rd_data` 4'h0, `wr_ready` 1, `count` 0. Storage contents are not reset.
- Reset asserted mid-stream empties the queue immediately. Outputs take their reset values without waiting for a clock edge.
- `rd_data` is combinational from registered state. It is valid in the same cycle `rd_next` is high, so the decoder latches it on that edge.
- Write-to-read latency is 1 cycle. A nibble written at edge N appears on `rd_data` after edge N; there is no same-cycle bypass.
- Simultaneous write and read when full: read proceeds, write is rejected (`wr_ready` was 0).
- Simultaneous write and read when empty: write accepted, read ignored.
- `rewind` and `rd_next` in the same cycle: `rewind` wins; `rd_ptr` <= `base_ptr`.
- `release` and `rd_next` in the same cycle: `base_ptr` <= the pre-increment `rd_ptr`, and `rd_ptr` increments.
- `release` and `rewind` in the same cycle: `base_ptr` <= `rd_ptr`, and `rd_ptr` is unchanged.

## Configuration
- `OP_FETCH_REPLAY_EN` defined:
  - `rewind` and `release` ports exist.
  - `base_ptr` is an independent register.
  - Consumed entries remain occupied until `release`.
- Not defined:
  - `rewind` and `release` ports are absent.
  - `base_ptr` is a wire equal to `rd_ptr`.
  - The block behaves as a plain FIFO.

## Structure
- Shared constants package:
  - `NIBBLE_W` = 4
  - `OP_NOP` = 4'h0
  - `OP_PUSH` = 4'h1, `OP_POP` = 4'h2, `OP_SAVE` = 4'h3, `OP_LOAD` = 4'h4
- One sub-module, `nibble_ram`: DEPTH x 4 storage with a synchronous write port and an asynchronous read port, no reset.
- Pointer, count, handshake and replay logic live in `op_fetch_queue`.

## Test plan
- Reset, then write 1,7,2 with `rd_next` low: `count`=3 and `rd_data`=1. Pulse `rd_next` three times: `rd_data` goes 7, 2, 0; `rd_valid` then 0 and `count`=0.
- Fill DEPTH=8 with 0..7: `wr_ready`=0. Write 9: `ovf`=1 and `count` stays 8. Drain all: read order 0..7, with no 9.
- Full queue, write and `rd_next` in the same cycle: read advances, write is rejected, `count`=7, `wr_ready`=1 the next cycle.
- Write/read 20 nibbles continuously with DEPTH=8: pointers wrap, data order is preserved, `count` never exceeds 8.
- Assert `rst_n`=0 with 5 entries queued, between edges: `rd_valid` 0 and `rd_data` 0 immediately; `count` 0 after release.
- REPLAY_EN: write 1,5,2. Read three times, then `rewind`: `rd_data`=1 again and `count`=3. Then `release` after one read: `count`=2.

Source files
------------

// File: rtl/op_fetch_queue_pkg.sv
// Shared constants for the op fetch queue and the op decoder it feeds.
// Nibble width and the opcode encodings the decoder understands.
package op_fetch_queue_pkg;

    localparam int NIBBLE_W = 4;

    typedef logic [NIBBLE_W-1:0] nibble_t;

    localparam nibble_t OP_NOP  = 4'h0;
    localparam nibble_t OP_PUSH = 4'h1;
    localparam nibble_t OP_POP  = 4'h2;
    localparam nibble_t OP_SAVE = 4'h3;
    localparam nibble_t OP_LOAD = 4'h4;

endpackage

// File: rtl/op_fetch_queue_nibble_ram.sv
// DEPTH x 4 nibble storage: synchronous write, asynchronous read, no reset.
// Read data follows the read address combinationally.
module nibble_ram
    import op_fetch_queue_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  nibble_t       wdata_i,
    input  logic [AW-1:0] raddr_i,
    output nibble_t       rdata_o
);

    nibble_t mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/op_fetch_queue.sv
// Nibble instruction queue ahead of the op decoder; head is combinational, 1-cycle write-to-read.
// Optional loop replay (rewind/release ports) is built when OP_FETCH_REPLAY_EN is defined.
module op_fetch_queue
    import op_fetch_queue_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   wr_valid_i,
    input  nibble_t                wr_data_i,
    output logic                   wr_ready_o,
    input  logic                   rd_next_i,
    output nibble_t                rd_data_o,
    output logic                   rd_valid_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   ovf_o
`ifdef OP_FETCH_REPLAY_EN
    ,
    input  logic                   rewind_i,
    input  logic                   release_i
`endif
);

    localparam int AW = $clog2(DEPTH);

    typedef logic [AW:0] ptr_t;

    localparam ptr_t PTR_ONE  = ptr_t'(1);
    localparam ptr_t FULL_CNT = ptr_t'(DEPTH);

    ptr_t    wr_ptr_q, wr_ptr_d;
    ptr_t    rd_ptr_q, rd_ptr_d;
    ptr_t    base_ptr;
    logic    ovf_q, ovf_d;
    logic    wr_fire, rd_fire;
    nibble_t ram_rdata;

    // Occupancy runs from base_ptr, so entries kept for replay still count.
    assign count_o    = wr_ptr_q - base_ptr;
    assign wr_ready_o = (count_o != FULL_CNT);
    assign rd_valid_o = (rd_ptr_q != wr_ptr_q);
    assign wr_fire    = wr_valid_i && wr_ready_o;
    assign rd_fire    = rd_next_i && rd_valid_o;
    assign rd_data_o  = rd_valid_o ? ram_rdata : OP_NOP;
    assign ovf_o      = ovf_q;

    nibble_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (wr_fire),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wdata_i (wr_data_i),
        .raddr_i (rd_ptr_q[AW-1:0]),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        ovf_d    = ovf_q | (wr_valid_i & ~wr_ready_o);
        if (wr_fire) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
    end

`ifdef OP_FETCH_REPLAY_EN
    ptr_t base_ptr_q, base_ptr_d;

    assign base_ptr = base_ptr_q;

    // Rewind beats a read; with a simultaneous release the new base is the
    // current read point, so the read pointer simply stays put.
    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        base_ptr_d = base_ptr_q;
        if (release_i) begin
            base_ptr_d = rd_ptr_q;
        end
        if (rewind_i) begin
            rd_ptr_d = release_i ? rd_ptr_q : base_ptr_q;
        end else if (rd_fire) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            base_ptr_q <= '0;
        end else begin
            base_ptr_q <= base_ptr_d;
        end
    end
`else
    assign base_ptr = rd_ptr_q;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        if (rd_fire) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
        end
    end

endmodule
